mcu_run_controller: RTL and testbench

Synthesizable run controller and bus-trace capture unit for the MCU32X core. It sequences the core's reset with a configurable hold and bounds each run with a cycle budget or a halt. It also captures memory-bus activity (result, address, mem_read, mem_write) into a FIFO that a host or bench drains through a valid/ready port. It replaces the fixed reset-release, cycle-limit and print monitoring with a parametrised on-chip block usable in silicon debug and simulation alike.

---
 rtl/mcu_run_controller_if.sv | 18 +
 rtl/mcu_run_controller.sv | 162 ++++++++++++++++
 tb/tb_mcu_run_controller.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_run_controller_if.sv
// Trace-drain port of mcu_run_controller: FWFT FIFO head plus occupancy.
// The controller drives the master side; the host or bench takes the slave side.
interface mcu_run_controller_if #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TRACE_DEPTH = 16
);
  localparam int REC_W  = DATA_W + ADDR_W + 2;
  localparam int TCNT_W = $clog2(TRACE_DEPTH) + 1;

  logic              trace_valid;
  logic [REC_W-1:0]  trace_data;
  logic              trace_ready;
  logic [TCNT_W-1:0] trace_count;

  modport master (output trace_valid, output trace_data, output trace_count, input  trace_ready);
  modport slave  (input  trace_valid, input  trace_data, input  trace_count, output trace_ready);
endinterface

// File: rtl/mcu_run_controller.sv
// Run controller for the MCU32X core: reset hold, cycle-budgeted run, halt detection,
// and a first-word-fall-through FIFO capturing memory-bus records during RUN.
module mcu_run_controller #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int RESET_CYCLES = 3,
  parameter int MAX_CYCLES   = 20,
  parameter int CNT_W        = 16,
  parameter int TRACE_DEPTH  = 16,
  parameter int CAPTURE_ALL  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  output logic              core_reset,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  cycle_o,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  mcu_run_controller_if.master trace
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_e;

  localparam int PTR_W  = $clog2(TRACE_DEPTH);
  localparam int TCNT_W = PTR_W + 1;
  localparam int REC_W  = DATA_W + ADDR_W + 2;
  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [TCNT_W-1:0] DEPTH_CNT = TCNT_W'(TRACE_DEPTH);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic                timeout_q, timeout_d;
  logic                overflow_q, overflow_d;
  logic                core_reset_q, done_q;
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [TCNT_W-1:0]   count_q, count_d;
  logic [REC_W-1:0]    mem_q [TRACE_DEPTH];

  logic flush, run_cycle, capture, full, pop, push, drop;
  logic [REC_W-1:0] record;

  assign record  = {mem_write_i, mem_read_i, address_i, result_i};
  assign capture = run_cycle && ((CAPTURE_ALL != 0) || mem_read_i || mem_write_i);
  assign full    = (count_q == DEPTH_CNT);
  assign pop     = (count_q != '0) && trace.trace_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cycle_d    = cycle_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    flush      = 1'b0;
    run_cycle  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = HOLD;
          hold_d     = '0;
          cycle_d    = '0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
          flush      = 1'b1;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) state_d = RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      RUN: begin
        run_cycle = 1'b1;
        if (cycle_q != MAX_CNT) cycle_d = cycle_q + 1'b1;
        if (halt_i) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if ((cycle_q + 1'b1) == MAX_CNT) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (drop) overflow_d = 1'b1;
  end

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      cycle_q      <= '0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cycle_q      <= cycle_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
      core_reset_q <= (state_d != RUN);
      done_q       <= (state_d == DONE);
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
    end
  end

  // NOTE: record storage has no reset; stale words are never visible because trace_valid follows count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= record;
  end

  assign state_o           = state_q;
  assign cycle_o           = cycle_q;
  assign timeout           = timeout_q;
  assign overflow          = overflow_q;
  assign core_reset        = core_reset_q;
  assign done              = done_q;
  assign trace.trace_valid = (count_q != '0);
  assign trace.trace_data  = mem_q[rd_q];
  assign trace.trace_count = count_q;

endmodule

// File: tb/tb_mcu_run_controller.sv
// Bench for mcu_run_controller: two instances (selective capture depth 16, capture-all depth 4)
// share stimulus; status is checked directly, trace records through per-instance scoreboards.
module tb_mcu_run_controller;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic [DW-1:0] result = '0;
  logic [AW-1:0] address = '0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;

  logic          sel_cr, sel_done, sel_to, sel_ovf;
  logic [1:0]    sel_state;
  logic [CW-1:0] sel_cycle;
  logic          all_cr, all_done, all_to, all_ovf;
  logic [1:0]    all_state;
  logic [CW-1:0] all_cycle;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW+AW+1:0] exp_sel [$];
  logic [DW+AW+1:0] exp_all [$];

  mcu_run_controller_if #(.DATA_W(DW), .ADDR_W(AW), .TRACE_DEPTH(16)) sel_if ();
  mcu_run_controller_if #(.DATA_W(DW), .ADDR_W(AW), .TRACE_DEPTH(4))  all_if ();

  mcu_run_controller #(.TRACE_DEPTH(16), .CAPTURE_ALL(0)) u_sel (
    .clk(clk), .reset(reset), .start(start), .halt_i(halt),
    .result_i(result), .address_i(address), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .core_reset(sel_cr), .state_o(sel_state), .cycle_o(sel_cycle), .done(sel_done),
    .timeout(sel_to), .overflow(sel_ovf), .trace(sel_if.master)
  );

  mcu_run_controller #(.TRACE_DEPTH(4), .CAPTURE_ALL(1)) u_all (
    .clk(clk), .reset(reset), .start(start), .halt_i(halt),
    .result_i(result), .address_i(address), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .core_reset(all_cr), .state_o(all_state), .cycle_o(all_cycle), .done(all_done),
    .timeout(all_to), .overflow(all_ovf), .trace(all_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a pop happens on the next edge whenever valid & ready is seen here.
  always @(negedge clk) begin
    if (sel_if.trace_valid && sel_if.trace_ready) begin
      n_cmp++;
      if (exp_sel.size() == 0) begin
        n_err++;
        $display("FAIL sel_trace: got %h expected no record", sel_if.trace_data);
      end else begin
        if (sel_if.trace_data !== exp_sel[0]) begin
          n_err++;
          $display("FAIL sel_trace: got %h expected %h", sel_if.trace_data, exp_sel[0]);
        end
        void'(exp_sel.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (all_if.trace_valid && all_if.trace_ready) begin
      n_cmp++;
      if (exp_all.size() == 0) begin
        n_err++;
        $display("FAIL all_trace: got %h expected no record", all_if.trace_data);
      end else begin
        if (all_if.trace_data !== exp_all[0]) begin
          n_err++;
          $display("FAIL all_trace: got %h expected %h", all_if.trace_data, exp_all[0]);
        end
        void'(exp_all.pop_front());
      end
    end
  end

  // Pulse start, confirm the cleared HOLD state, then walk to the first RUN cycle.
  task automatic run_to_run();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_hold_state", sel_state, 2'd1);
    check("start_done_clr", sel_done, 1'b0);
    check("start_cycle_clr", sel_cycle, 0);
    check("start_flush", sel_if.trace_count, 0);
    check("start_all_flush", all_if.trace_count, 0);
    check("start_ovf_clr", all_ovf, 1'b0);
    repeat (3) step();
    check("run_state", sel_state, 2'd2);
    check("run_core_reset", sel_cr, 1'b0);
  endtask

  initial begin
    sel_if.trace_ready = 1'b0;
    all_if.trace_ready = 1'b0;

    // Reset state
    repeat (2) step();
    reset = 1'b1;
    step();
    check("rst_core_reset", sel_cr, 1'b1);
    check("rst_state", sel_state, 2'd0);
    check("rst_done", sel_done, 1'b0);
    check("rst_valid", sel_if.trace_valid, 1'b0);
    check("rst_count", sel_if.trace_count, 0);
    check("rst_cycle", sel_cycle, 0);

    // Hold sequencing: HOLD for three cycles after the start edge, then RUN
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("hold_state_t%0d", i), sel_state, 2'd1);
      check($sformatf("hold_cr_t%0d", i), sel_cr, 1'b1);
      step();
    end
    check("hold_state_t4", sel_state, 2'd2);
    check("hold_cr_t4", sel_cr, 1'b0);

    // Selective capture, halt on run cycle 6
    for (int k = 1; k <= 6; k++) begin
      result    = 32'hCAFE_0000 + k;
      mem_write = (k == 2);
      mem_read  = (k == 4);
      address   = (k == 2) ? 32'h100 : (k == 4) ? 32'h104 : 32'h0;
      halt      = (k == 6);
      if (k == 2) exp_sel.push_back({1'b1, 1'b0, 32'h100, 32'hCAFE_0002});
      if (k == 4) exp_sel.push_back({1'b0, 1'b1, 32'h104, 32'hCAFE_0004});
      step();
    end
    {mem_write, mem_read, halt, address} = '0;
    check("halt6_done", sel_done, 1'b1);
    check("halt6_timeout", sel_to, 1'b0);
    check("halt6_cycle", sel_cycle, 6);
    check("halt6_state", sel_state, 2'd3);
    check("halt6_core_reset", sel_cr, 1'b1);
    check("halt6_count", sel_if.trace_count, 2);
    sel_if.trace_ready = 1'b1;
    for (int i = 0; i < 10 && sel_if.trace_valid; i++) step();
    sel_if.trace_ready = 1'b0;
    check("halt6_drained", sel_if.trace_valid, 1'b0);
    check("halt6_sb_empty", exp_sel.size(), 0);

    // Budget expiry after 20 RUN cycles
    run_to_run();
    repeat (19) step();
    check("budget_state19", sel_state, 2'd2);
    check("budget_cycle19", sel_cycle, 19);
    step();
    check("budget_state", sel_state, 2'd3);
    check("budget_timeout", sel_to, 1'b1);
    check("budget_cycle", sel_cycle, 20);
    check("budget_done", sel_done, 1'b1);
    step();
    check("budget_frozen", sel_cycle, 20);

    // Halt on the budget cycle: halt wins
    run_to_run();
    repeat (19) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("tie_timeout", sel_to, 1'b0);
    check("tie_cycle", sel_cycle, 20);
    check("tie_done", sel_done, 1'b1);

    // Capture-all into depth-4 FIFO: fill, push+pop while full, then overflow
    run_to_run();
    for (int k = 1; k <= 9; k++) begin
      result  = 32'h1000 + k;
      address = 32'h2000 + 4 * k;
      halt    = (k == 9);
      all_if.trace_ready = (k == 5);
      if (k <= 5) exp_all.push_back({2'b00, 32'h2000 + 4 * k, 32'h1000 + k});
      step();
      all_if.trace_ready = 1'b0;
      if (k == 4) begin
        check("fill_count", all_if.trace_count, 4);
        check("fill_ovf", all_ovf, 1'b0);
      end
      if (k == 5) begin
        check("pushpop_count", all_if.trace_count, 4);
        check("pushpop_ovf", all_ovf, 1'b0);
      end
      if (k == 8) begin
        check("ovf_count", all_if.trace_count, 4);
        check("ovf_set", all_ovf, 1'b1);
      end
    end
    {halt, address, result} = '0;
    check("ovf_state", all_state, 2'd3);
    check("ovf_cycle", all_cycle, 9);
    check("ovf_sticky", all_ovf, 1'b1);
    check("sel_no_capture", sel_if.trace_count, 0);
    all_if.trace_ready = 1'b1;
    for (int i = 0; i < 10 && all_if.trace_valid; i++) step();
    all_if.trace_ready = 1'b0;
    check("ovf_drained", all_if.trace_valid, 1'b0);
    check("ovf_sb_empty", exp_all.size(), 0);

    // Start from DONE discards unread records
    run_to_run();
    mem_write = 1'b1;
    address   = 32'h300;
    step();
    halt = 1'b1;
    step();
    {halt, mem_write, address} = '0;
    check("flush_pre_done", sel_done, 1'b1);
    check("flush_pre_count", sel_if.trace_count, 2);

    // Reset asserted mid-RUN with three records queued
    run_to_run();
    mem_write = 1'b1;
    repeat (3) step();
    mem_write = 1'b0;
    check("midrst_pre_count", sel_if.trace_count, 3);
    reset = 1'b0;
    step();
    check("midrst_state", sel_state, 2'd0);
    check("midrst_core_reset", sel_cr, 1'b1);
    check("midrst_cycle", sel_cycle, 0);
    check("midrst_count", sel_if.trace_count, 0);
    check("midrst_ovf", all_ovf, 1'b0);
    check("midrst_all_count", all_if.trace_count, 0);
    reset = 1'b1;
    step();
    check("midrst_idle", sel_state, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
